// File: rtl/break_arbiter.sv
// Data-break (DMA) arbiter: picks one of NCH break channels, drives a single
// memory break cycle of MEM_LAT clocks toward ma, then pulses that channel's ack.
module break_arbiter #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned MODE    = 1,
    parameter int unsigned BURST   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              break_ok,
    input  logic [NCH-1:0]    req,
    input  logic [15*NCH-1:0] ch_addr,
    input  logic [12*NCH-1:0] ch_wdata,
    input  logic [NCH-1:0]    ch_to_dev,
    input  logic [11:0]       mem_rdata,
    output logic              data_break,
    output logic              to_dev,
    output logic [14:0]       break_addr,
    output logic [11:0]       break_wdata,
    output logic              break_in_prog,
    output logic [NCH-1:0]    ack,
    output logic [11:0]       rdata,
    output logic [2:0]        grant_ch
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned LW = $clog2(MEM_LAT + 1);
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BREAK = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [BW-1:0] burst_cnt;
    logic [LW-1:0] lat_cnt;

    logic [IW-1:0]  last_c;
    logic [NCH-1:0] elig_c;
    logic [IW-1:0]  win_c;
    logic           win_valid_c;
    logic [14:0]    win_addr_c;
    logic [11:0]    win_wdata_c;
    logic           win_to_dev_c;
    int             idx;

    // Requesters allowed to compete: the last winner sits out once it has used its burst.
    always_comb begin
        last_c = grant_ch[IW-1:0];
        elig_c = req;
        if (MODE == 1 && burst_cnt >= BW'(BURST)) begin
            if ((req & ~(NCH'(1) << last_c)) != '0) begin
                elig_c[last_c] = 1'b0;
            end
        end
    end

    // Scan from the round-robin pointer (or from 0 in fixed mode); first eligible wins.
    always_comb begin
        win_c       = '0;
        win_valid_c = 1'b0;
        idx         = 0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            idx = (MODE == 1) ? (int'(rr_ptr) + k) % int'(NCH) : k;
            if (elig_c[IW'(idx)]) begin
                win_c       = IW'(idx);
                win_valid_c = 1'b1;
            end
        end
        win_addr_c   = ch_addr[15*int'(win_c) +: 15];
        win_wdata_c  = ch_wdata[12*int'(win_c) +: 12];
        win_to_dev_c = ch_to_dev[win_c];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            burst_cnt     <= '0;
            lat_cnt       <= '0;
            data_break    <= 1'b0;
            to_dev        <= 1'b0;
            break_addr    <= '0;
            break_wdata   <= '0;
            break_in_prog <= 1'b0;
            ack           <= '0;
            rdata         <= '0;
            grant_ch      <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        rr_ptr    <= '0;
                        burst_cnt <= '0;
                    end else if (break_ok && win_valid_c) begin
                        state         <= GRANT;
                        grant_ch      <= 3'(win_c);
                        break_addr    <= win_addr_c;
                        break_wdata   <= win_wdata_c;
                        to_dev        <= win_to_dev_c;
                        break_in_prog <= 1'b1;
                        if (MODE == 1) begin
                            rr_ptr <= (win_c == IW'(NCH - 1)) ? '0 : win_c + 1'b1;
                            if (win_c == last_c) begin
                                burst_cnt <= (burst_cnt >= BW'(BURST)) ? burst_cnt
                                                                       : burst_cnt + 1'b1;
                            end else begin
                                burst_cnt <= BW'(1);
                            end
                        end
                    end
                end
                GRANT: begin
                    state      <= BREAK;
                    data_break <= 1'b1;
                    lat_cnt    <= LW'(MEM_LAT);
                end
                BREAK: begin
                    if (lat_cnt == LW'(1)) begin
                        state      <= ACK;
                        data_break <= 1'b0;
                        ack        <= NCH'(1) << grant_ch;
                        if (to_dev) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ACK: begin
                    state         <= IDLE;
                    break_in_prog <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_break_arbiter.sv
// Bench for break_arbiter: fixed-priority (2 ch), round-robin (3 ch, burst 2) and
// single-channel instances, with directed scenarios and a timed reference model.
module tb_break_arbiter;

    localparam int MEM_LAT  = 2;
    localparam int RR_BURST = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clear, break_ok;
    logic [11:0] mem_rdata;

    logic [1:0]  fp_req, fp_to_dev, fp_ack;
    logic [29:0] fp_addr;
    logic [23:0] fp_wdata;
    logic        fp_db, fp_tdev, fp_bip;
    logic [14:0] fp_baddr;
    logic [11:0] fp_bwdata, fp_rdata;
    logic [2:0]  fp_gch;

    logic [2:0]  rr_req, rr_to_dev, rr_ack;
    logic [44:0] rr_addr;
    logic [35:0] rr_wdata;
    logic        rr_db, rr_tdev, rr_bip;
    logic [14:0] rr_baddr;
    logic [11:0] rr_bwdata, rr_rdata;
    logic [2:0]  rr_gch;

    logic [0:0]  one_req, one_to_dev, one_ack;
    logic [14:0] one_addr;
    logic [11:0] one_wdata;
    logic        one_db, one_tdev, one_bip;
    logic [14:0] one_baddr;
    logic [11:0] one_bwdata, one_rdata;
    logic [2:0]  one_gch;

    int checks = 0;
    int errors = 0;

    break_arbiter #(.NCH(2), .MEM_LAT(MEM_LAT), .MODE(0), .BURST(4)) u_fp (
        .clk(clk), .reset(reset), .clear(clear), .break_ok(break_ok),
        .req(fp_req), .ch_addr(fp_addr), .ch_wdata(fp_wdata), .ch_to_dev(fp_to_dev),
        .mem_rdata(mem_rdata), .data_break(fp_db), .to_dev(fp_tdev),
        .break_addr(fp_baddr), .break_wdata(fp_bwdata), .break_in_prog(fp_bip),
        .ack(fp_ack), .rdata(fp_rdata), .grant_ch(fp_gch)
    );

    break_arbiter #(.NCH(3), .MEM_LAT(MEM_LAT), .MODE(1), .BURST(RR_BURST)) u_rr (
        .clk(clk), .reset(reset), .clear(clear), .break_ok(break_ok),
        .req(rr_req), .ch_addr(rr_addr), .ch_wdata(rr_wdata), .ch_to_dev(rr_to_dev),
        .mem_rdata(mem_rdata), .data_break(rr_db), .to_dev(rr_tdev),
        .break_addr(rr_baddr), .break_wdata(rr_bwdata), .break_in_prog(rr_bip),
        .ack(rr_ack), .rdata(rr_rdata), .grant_ch(rr_gch)
    );

    break_arbiter #(.NCH(1), .MEM_LAT(MEM_LAT), .MODE(1), .BURST(4)) u_one (
        .clk(clk), .reset(reset), .clear(clear), .break_ok(break_ok),
        .req(one_req), .ch_addr(one_addr), .ch_wdata(one_wdata), .ch_to_dev(one_to_dev),
        .mem_rdata(mem_rdata), .data_break(one_db), .to_dev(one_tdev),
        .break_addr(one_baddr), .break_wdata(one_bwdata), .break_in_prog(one_bip),
        .ack(one_ack), .rdata(one_rdata), .grant_ch(one_gch)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({fp_db, fp_tdev, fp_bip, fp_ack, fp_gch, fp_baddr, fp_bwdata, fp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_fp: got %h want 0",
                     {fp_db, fp_tdev, fp_bip, fp_ack, fp_gch, fp_baddr, fp_bwdata, fp_rdata});
        end
        checks++;
        if ({rr_db, rr_tdev, rr_bip, rr_ack, rr_gch, rr_baddr, rr_bwdata, rr_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_rr: got %h want 0",
                     {rr_db, rr_tdev, rr_bip, rr_ack, rr_gch, rr_baddr, rr_bwdata, rr_rdata});
        end
        checks++;
        if ({one_db, one_tdev, one_bip, one_ack, one_gch, one_baddr, one_bwdata, one_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_one: got %h want 0",
                     {one_db, one_tdev, one_bip, one_ack, one_gch, one_baddr, one_bwdata, one_rdata});
        end
    endtask

    task automatic test_single_read();
        fp_addr[29:15] = 15'o10200;
        fp_to_dev      = 2'b10;
        mem_rdata      = 12'o5252;
        break_ok       = 1'b1;
        fp_req         = 2'b10;
        tick();
        checks++;
        if ({fp_baddr, fp_bip, fp_db, fp_gch, fp_tdev} !== {15'o10200, 1'b1, 1'b0, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL read_grant: got addr=%o bip=%b db=%b gch=%0d tdev=%b want 10200 1 0 1 1",
                     fp_baddr, fp_bip, fp_db, fp_gch, fp_tdev);
        end
        for (int i = 0; i < MEM_LAT; i++) begin
            tick();
            checks++;
            if (fp_db !== 1'b1 || fp_ack !== 2'b00) begin
                errors++;
                $display("FAIL read_break%0d: got db=%b ack=%b want 1 00", i, fp_db, fp_ack);
            end
        end
        tick();
        checks++;
        if ({fp_ack, fp_rdata, fp_db} !== {2'b10, 12'o5252, 1'b0}) begin
            errors++;
            $display("FAIL read_ack: got ack=%b rdata=%o db=%b want 10 5252 0", fp_ack, fp_rdata, fp_db);
        end
        fp_req = 2'b00;
        tick();
        checks++;
        if (fp_ack !== 2'b00 || fp_bip !== 1'b0) begin
            errors++;
            $display("FAIL read_done: got ack=%b bip=%b want 00 0", fp_ack, fp_bip);
        end
    endtask

    task automatic test_write_gated();
        fp_wdata[11:0] = 12'o7777;
        fp_to_dev      = 2'b00;
        break_ok       = 1'b0;
        fp_req         = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (fp_db !== 1'b0 || fp_bip !== 1'b0) begin
                errors++;
                $display("FAIL gated_%0d: got db=%b bip=%b want 0 0", i, fp_db, fp_bip);
            end
        end
        break_ok = 1'b1;
        tick();
        checks++;
        if ({fp_bip, fp_bwdata, fp_tdev, fp_gch} !== {1'b1, 12'o7777, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL write_grant: got bip=%b wdata=%o tdev=%b gch=%0d want 1 7777 0 0",
                     fp_bip, fp_bwdata, fp_tdev, fp_gch);
        end
        repeat (MEM_LAT + 1) tick();
        checks++;
        if (fp_ack !== 2'b01) begin
            errors++;
            $display("FAIL write_ack: got %b want 01", fp_ack);
        end
        fp_req = 2'b00;
        tick();
    endtask

    task automatic test_clear();
        fp_req   = 2'b01;
        break_ok = 1'b1;
        clear    = 1'b1;
        tick();
        checks++;
        if (fp_bip !== 1'b0) begin
            errors++;
            $display("FAIL clear_block: got bip=%b want 0", fp_bip);
        end
        clear = 1'b0;
        tick();
        checks++;
        if (fp_bip !== 1'b1) begin
            errors++;
            $display("FAIL clear_release: got bip=%b want 1", fp_bip);
        end
        repeat (MEM_LAT + 1) tick();
        checks++;
        if (fp_ack !== 2'b01) begin
            errors++;
            $display("FAIL clear_ack: got %b want 01", fp_ack);
        end
        fp_req = 2'b00;
        tick();
    endtask

    task automatic test_fixed_priority();
        logic [1:0] exp_ack;
        fp_req   = 2'b11;
        break_ok = 1'b1;
        for (int n = 0; n < 30; n++) begin
            tick();
            exp_ack = (n % (MEM_LAT + 3) == MEM_LAT + 1) ? 2'b01 : 2'b00;
            checks++;
            if (fp_ack !== exp_ack) begin
                errors++;
                $display("FAIL fixed_prio cyc %0d: got ack=%b want %b", n, fp_ack, exp_ack);
            end
        end
        fp_req = 2'b00;
        tick();
    endtask

    task automatic test_req_drop();
        fp_req   = 2'b01;
        break_ok = 1'b1;
        repeat (MEM_LAT + 1) tick();
        fp_req = 2'b00;
        tick();
        checks++;
        if (fp_ack !== 2'b01) begin
            errors++;
            $display("FAIL drop_ack: got %b want 01", fp_ack);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (fp_ack !== 2'b00 || fp_bip !== 1'b0) begin
                errors++;
                $display("FAIL drop_idle_%0d: got ack=%b bip=%b want 00 0", i, fp_ack, fp_bip);
            end
        end
    endtask

    task automatic test_reset_mid_break();
        fp_addr[29:15] = 15'o4321;
        fp_req         = 2'b10;
        break_ok       = 1'b1;
        repeat (2) tick();
        checks++;
        if (fp_db !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got db=%b want 1", fp_db);
        end
        reset  = 1'b1;
        fp_req = 2'b00;
        tick();
        checks++;
        if ({fp_db, fp_bip, fp_ack, fp_baddr, fp_gch} !== '0) begin
            errors++;
            $display("FAIL midrst: got db=%b bip=%b ack=%b addr=%o gch=%0d want all 0",
                     fp_db, fp_bip, fp_ack, fp_baddr, fp_gch);
        end
        reset  = 1'b0;
        fp_req = 2'b10;
        repeat (MEM_LAT + 2) tick();
        checks++;
        if (fp_ack !== 2'b10 || fp_baddr !== 15'o4321) begin
            errors++;
            $display("FAIL midrst_resume: got ack=%b addr=%o want 10 4321", fp_ack, fp_baddr);
        end
        fp_req = 2'b00;
        tick();
    endtask

    task automatic test_nch1();
        one_addr   = 15'o17012;
        one_to_dev = 1'b1;
        mem_rdata  = 12'o1234;
        break_ok   = 1'b1;
        one_req    = 1'b1;
        tick();
        checks++;
        if (one_gch !== 3'd0 || one_baddr !== 15'o17012 || one_bip !== 1'b1) begin
            errors++;
            $display("FAIL nch1_grant: got gch=%0d addr=%o bip=%b want 0 17012 1", one_gch, one_baddr, one_bip);
        end
        repeat (MEM_LAT + 1) tick();
        checks++;
        if (one_ack !== 1'b1 || one_rdata !== 12'o1234) begin
            errors++;
            $display("FAIL nch1_ack: got ack=%b rdata=%o want 1 1234", one_ack, one_rdata);
        end
        one_req = 1'b0;
        tick();
    endtask

    task automatic test_rr_burst();
        int n_ack;
        int budget;
        int exp_ch;
        reset  = 1'b1;
        rr_req = 3'b000;
        tick();
        reset    = 1'b0;
        break_ok = 1'b1;
        rr_req   = 3'b111;
        n_ack    = 0;
        budget   = 0;
        while (n_ack < 10 && budget < 100) begin
            tick();
            budget++;
            if (rr_ack !== 3'b000) begin
                exp_ch = (n_ack < 6) ? n_ack % 3 : 0;
                checks++;
                if (rr_ack !== 3'(1 << exp_ch) || rr_gch !== 3'(exp_ch)) begin
                    errors++;
                    $display("FAIL rr_seq grant %0d: got ack=%b gch=%0d want ch %0d",
                             n_ack, rr_ack, rr_gch, exp_ch);
                end
                n_ack++;
                if (n_ack == 6) rr_req = 3'b001;
            end
        end
        checks++;
        if (n_ack < 10) begin
            errors++;
            $display("FAIL rr_seq_timeout: got %0d acks want 10", n_ack);
        end
        rr_req = 3'b000;
        repeat (2) tick();
    endtask

    // Timed model: a grant at edge t0 shows break_in_prog t0..t0+MEM_LAT+1,
    // data_break t0+1..t0+MEM_LAT, ack at t0+MEM_LAT+1, next arbitration at t0+MEM_LAT+3.
    task automatic test_rr_random(input int ncyc);
        int ptr, last, run, win, t0, free_at, cc;
        bit found;
        logic [2:0]  el, ack_e, e_gch;
        logic [14:0] e_addr;
        logic [11:0] e_wdata, e_rdata;
        logic        e_tdev, e_db, e_bip;
        logic [47:0] exp_v, got_v;
        reset  = 1'b1;
        rr_req = 3'b000;
        clear  = 1'b0;
        tick();
        reset   = 1'b0;
        ptr     = 0;
        last    = 0;
        run     = 0;
        win     = 0;
        t0      = -100;
        free_at = 0;
        e_addr  = '0;
        e_wdata = '0;
        e_rdata = '0;
        e_tdev  = 1'b0;
        e_gch   = '0;
        for (int n = 0; n < ncyc; n++) begin
            for (int c = 0; c < 3; c++) begin
                if (rr_ack[c]) rr_req[c] = 1'b0;
                else if (!rr_req[c] && $urandom_range(3) == 0) rr_req[c] = 1'b1;
            end
            rr_addr   = 45'({$urandom(), $urandom()});
            rr_wdata  = 36'({$urandom(), $urandom()});
            rr_to_dev = 3'($urandom());
            mem_rdata = 12'($urandom());
            break_ok  = ($urandom_range(3) != 0);
            clear     = ($urandom_range(15) == 0);
            if (n == t0 + MEM_LAT + 1 && e_tdev) e_rdata = mem_rdata;
            if (n >= free_at) begin
                if (clear) begin
                    ptr = 0;
                    run = 0;
                end else if (break_ok && rr_req != 3'b000) begin
                    el = rr_req;
                    if (run >= RR_BURST && (rr_req & ~(3'b001 << last)) != 3'b000) el[last] = 1'b0;
                    found = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        cc = (ptr + k) % 3;
                        if (!found && el[cc]) begin
                            win   = cc;
                            found = 1'b1;
                        end
                    end
                    run     = (win == last) ? run + 1 : 1;
                    last    = win;
                    ptr     = (win + 1) % 3;
                    t0      = n;
                    free_at = n + MEM_LAT + 3;
                    e_addr  = rr_addr[win*15 +: 15];
                    e_wdata = rr_wdata[win*12 +: 12];
                    e_tdev  = rr_to_dev[win];
                    e_gch   = 3'(win);
                end
            end
            tick();
            e_bip = (n >= t0 && n <= t0 + MEM_LAT + 1);
            e_db  = (n >= t0 + 1 && n <= t0 + MEM_LAT);
            ack_e = (n == t0 + MEM_LAT + 1) ? 3'(1 << win) : 3'b000;
            exp_v = {e_db, e_bip, ack_e, e_gch, e_addr, e_wdata, e_tdev, e_rdata};
            got_v = {rr_db, rr_bip, rr_ack, rr_gch, rr_baddr, rr_bwdata, rr_tdev, rr_rdata};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL rr_random cyc %0d: got %h want %h", n, got_v, exp_v);
            end
        end
        clear    = 1'b0;
        rr_req   = 3'b000;
        break_ok = 1'b0;
        repeat (MEM_LAT + 3) tick();
    endtask

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        break_ok   = 1'b0;
        mem_rdata  = '0;
        fp_req     = '0;
        fp_to_dev  = '0;
        fp_addr    = '0;
        fp_wdata   = '0;
        rr_req     = '0;
        rr_to_dev  = '0;
        rr_addr    = '0;
        rr_wdata   = '0;
        one_req    = '0;
        one_to_dev = '0;
        one_addr   = '0;
        one_wdata  = '0;
        test_reset();
        test_single_read();
        test_write_gated();
        test_clear();
        test_fixed_priority();
        test_req_drop();
        test_reset_mid_break();
        test_nch1();
        test_rr_burst();
        test_rr_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/break_arbiter.md
Name: break_arbiter

Overview:
- Parametrised data-break (DMA) arbiter. It generalises the single-device data-break path (one disk controller driving data_break/to_disk/break_in_prog) to NCH break channels.
- Sits between the break-capable peripherals (RK8E and future devices) and ma/state_machine.
- Arbitrates pending requests (fixed or round-robin priority, with bounded bursts), sequences one memory break cycle at a time, and returns read data with a per-channel ack pulse.

Parameters:
- NCH, 2, number of break channels (1..8).
- MEM_LAT, 2, clk cycles data_break is held before memory data is valid / write committed (>=1).
- MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round robin.
- BURST, 4, max consecutive grants to one channel while others are requesting (>=1, MODE 1 only).

Ports:
- clk, input, 1, system clock (clk100 domain).
- reset, input, 1, synchronous, active-high.
- clear, input, 1, debounced front-panel clear (cleard).
- break_ok, input, 1, state_machine at a break-permitted point (instruction boundary/F-state end).
- req, input, NCH, per-channel break request; level, held until ack.
- ch_addr, input, 15*NCH, channel i at [i*15 +: 15]; field+address.
- ch_wdata, input, 12*NCH, channel i at [i*12 +: 12]; data to memory.
- ch_to_dev, input, NCH, 1 = memory read for device, 0 = device write to memory.
- mem_rdata, input, 12, mdout/mem2disk from ma.
- data_break, output, 1, break cycle active to ma.
- to_dev, output, 1, direction of current break (to ma as to_disk).
- break_addr, output, 15, dmaAddr to ma.
- break_wdata, output, 12, disk2mem-style write data to ma.
- break_in_prog, output, 1, to state_machine/D_mux; high from grant through ack.
- ack, output, NCH, one-cycle completion pulse, one-hot.
- rdata, output, 12, captured read data, valid in the ack cycle and held until the next ack.
- grant_ch, output, 3, channel index of current/last grant (D_mux status).

Behaviour:
- Reset: state IDLE; data_break, to_dev, break_in_prog, ack = 0; break_addr, break_wdata, rdata = 0; grant_ch = 0; RR pointer = 0; burst count = 0.
- States:
  - IDLE: if any req and break_ok, go to GRANT.
  - GRANT (1 cycle): pick the winner, latch its addr/wdata/to_dev into the output registers, set grant_ch and break_in_prog=1.
  - BREAK: data_break=1 for exactly MEM_LAT cycles.
  - ACK (1 cycle): data_break=0; ack[grant_ch]=1; if to_dev, rdata <= mem_rdata sampled in the last BREAK cycle; break_in_prog=0. Then IDLE.
- Latency: req with break_ok high to ack = MEM_LAT+2 cycles; back-to-back breaks are separated by one IDLE cycle minimum.
- Outputs are latched in GRANT; changes to ch_addr/ch_wdata/req during BREAK are ignored.
- A req dropped mid-break does not abort the cycle; the ack is still pulsed.
- MODE 0: lowest requesting index wins.
- MODE 1: search starts at the RR pointer.
  - Same winner as the previous grant increments the burst count; a different winner sets it to 1.
  - At burst count == BURST with another channel requesting, the current channel is excluded for that arbitration.
  - The pointer moves to the winner+1, mod NCH.
- break_ok low in IDLE: no grant, requests stay pending. break_ok is ignored once GRANT is entered.
- clear: in IDLE, resets the RR pointer and burst count and blocks a grant that cycle. During GRANT/BREAK/ACK it is ignored and the cycle completes.
- Reset mid-break: immediate return to IDLE with all outputs at reset values, and no ack.
- NCH=1: arbitration is trivial, and the design must elaborate with grant_ch = 0.

Test Plan:
- Single read: NCH=2, req[1]=1, ch_to_dev[1]=1, addr 15'o10200, mem_rdata=12'o5252, break_ok=1 -> break_addr=15'o10200, data_break high 2 cycles, ack=2'b10 at cycle 4, rdata=12'o5252.
- Write gated by break_ok: req[0]=1, ch_wdata=12'o7777, break_ok=0 for 10 cycles -> no data_break. Raise break_ok -> break_wdata=12'o7777, to_dev=0, ack[0] after 4 cycles.
- Fixed priority: MODE=0, req=2'b11 continuously -> channel 0 acked every 5 cycles, channel 1 never.
- Round-robin burst: MODE=1, BURST=2, NCH=3, req=3'b111 held -> grant sequence 0,1,2,0,1,2… With only req[0] held, channel 0 gets consecutive grants.
- Request drop: drop req[0] in the second BREAK cycle -> ack[0] still pulses and no second grant follows.
- Reset mid-break: assert reset in the BREAK state -> next cycle data_break=0, break_in_prog=0, ack=0. A re-raised req is serviced normally.
